// File: rtl/temp_convert_seq.sv
// Sequential Celsius/Fahrenheit converter built around a shared restoring divider.
// The result is rounded to nearest with ties away from zero, and saturated to OUT_W bits.
module temp_convert_seq #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int CH_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_temp,
  input  logic                    in_mode,
  input  logic [CH_W-1:0]         in_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_temp,
  output logic [CH_W-1:0]         out_ch,
  output logic                    out_sat,
  output logic [1:0]              dbg_state
);
  // Valid/ready: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready is high only in IDLE, and out_valid is high only in DONE.
  localparam int NW = IN_W + 4;
  localparam int AW = NW + 2;
  localparam int EW = ((AW > OUT_W) ? AW : OUT_W) + 1;
  localparam int CW = $clog2(NW);
  localparam logic [CW-1:0]        LAST_BIT = CW'(NW - 1);
  localparam logic signed [AW-1:0] OFS32    = AW'(32);
  localparam logic signed [EW-1:0] MAX_V    = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN_V    = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_t;

  state_t                  state_q, state_d;
  logic signed [IN_W-1:0]  temp_q, temp_d;
  logic                    mode_q, mode_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic                    neg_q, neg_d;
  logic [NW-1:0]           num_q, num_d;
  logic [3:0]              rem_q, rem_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [OUT_W-1:0] out_temp_q, out_temp_d;
  logic [CH_W-1:0]         out_ch_q, out_ch_d;
  logic                    out_sat_q, out_sat_d;

  logic [3:0]              div_v;
  logic signed [AW-1:0]    temp_s, n_s, q_s, r_s;
  logic [4:0]              trial;
  logic                    q_bit;
  logic [NW-1:0]           quot;
  logic signed [EW-1:0]    r_ext;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = PREP;
      PREP:    state_d = DIV;
      DIV:     if (cnt_q == LAST_BIT) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    dbg_state = state_q;
  end

  // The numerator magnitude shifts out MSB-first while quotient bits shift in at the LSB.
  always_comb begin
    div_v  = mode_q ? 4'd9 : 4'd5;
    temp_s = {{(AW-IN_W){temp_q[IN_W-1]}}, temp_q};
    n_s    = mode_q ? (((temp_s - OFS32) <<< 2) + (temp_s - OFS32))
                    : ((temp_s <<< 3) + temp_s);
    trial  = {rem_q, num_q[NW-1]};
    q_bit  = (trial >= {1'b0, div_v});
    quot   = {num_q[NW-2:0], q_bit};
    q_s    = {2'b00, quot};
    if (neg_q) q_s = -q_s;
    r_s    = mode_q ? q_s : (q_s + OFS32);
    r_ext  = {{(EW-AW){r_s[AW-1]}}, r_s};
  end

  always_comb begin
    temp_d     = temp_q;
    mode_d     = mode_q;
    ch_d       = ch_q;
    neg_d      = neg_q;
    num_d      = num_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    out_temp_d = out_temp_q;
    out_ch_d   = out_ch_q;
    out_sat_d  = out_sat_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          temp_d = in_temp;
          mode_d = in_mode;
          ch_d   = in_ch;
        end
      end
      PREP: begin
        neg_d = n_s[AW-1];
        num_d = NW'(n_s[AW-1] ? -n_s : n_s) + (mode_q ? NW'(4) : NW'(2));
        rem_d = '0;
        cnt_d = '0;
      end
      DIV: begin
        num_d = quot;
        rem_d = q_bit ? 4'(trial - {1'b0, div_v}) : trial[3:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          out_ch_d = ch_q;
          if (r_ext > MAX_V) begin
            out_temp_d = MAX_V[OUT_W-1:0];
            out_sat_d  = 1'b1;
          end else if (r_ext < MIN_V) begin
            out_temp_d = MIN_V[OUT_W-1:0];
            out_sat_d  = 1'b1;
          end else begin
            out_temp_d = r_ext[OUT_W-1:0];
            out_sat_d  = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      temp_q     <= '0;
      mode_q     <= 1'b0;
      ch_q       <= '0;
      neg_q      <= 1'b0;
      num_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      out_temp_q <= '0;
      out_ch_q   <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      temp_q     <= temp_d;
      mode_q     <= mode_d;
      ch_q       <= ch_d;
      neg_q      <= neg_d;
      num_q      <= num_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      out_temp_q <= out_temp_d;
      out_ch_q   <= out_ch_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign out_temp = out_temp_q;
  assign out_ch   = out_ch_q;
  assign out_sat  = out_sat_q;

endmodule

// File: tb/tb_temp_convert_seq.sv
// Bench for temp_convert_seq: a 16-bit-output and an 8-bit-output instance run in lockstep.
// Both instances are checked every cycle against a real-arithmetic model and a transaction timeline.
module tb_temp_convert_seq;
  localparam int IN_W = 8;
  localparam int NW   = IN_W + 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_temp = '0;
  logic        in_mode = 1'b0;
  logic [1:0]  in_ch = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_sat;
  logic [15:0] out_temp;
  logic [1:0]  out_ch, dbg_state;
  logic        in_ready8, out_valid8, out_sat8;
  logic [7:0]  out_temp8;
  logic [1:0]  out_ch8, dbg_state8;

  temp_convert_seq #(.IN_W(8), .OUT_W(16), .CH_W(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_temp(in_temp), .in_mode(in_mode), .in_ch(in_ch),
    .out_valid(out_valid), .out_ready(out_ready), .out_temp(out_temp),
    .out_ch(out_ch), .out_sat(out_sat), .dbg_state(dbg_state)
  );

  temp_convert_seq #(.IN_W(8), .OUT_W(8), .CH_W(2)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8),
    .in_temp(in_temp), .in_mode(in_mode), .in_ch(in_ch),
    .out_valid(out_valid8), .out_ready(out_ready), .out_temp(out_temp8),
    .out_ch(out_ch8), .out_sat(out_sat8), .dbg_state(dbg_state8)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  int present_cyc = 0;
  int valid_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected entry: {ch[27:26], sat8[25], temp8[24:17], sat16[16], temp16[15:0]}
  function automatic logic [27:0] model(input logic [7:0] t_raw, input logic m, input logic [1:0] ch);
    int t, q, r, r16, r8;
    real v;
    logic s16, s8;
    t = int'($signed(t_raw));
    v = m ? (t - 32) * 5.0 / 9.0 : t * 9.0 / 5.0;
    q = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    r = m ? q : q + 32;
    r16 = (r > 32767) ? 32767 : ((r < -32768) ? -32768 : r);
    r8  = (r > 127) ? 127 : ((r < -128) ? -128 : r);
    s16 = (r16 != r);
    s8  = (r8 != r);
    return {ch, s8, r8[7:0], s16, r16[15:0]};
  endfunction

  logic [27:0] exp_q[$];
  bit          pending = 0;
  int          acc_cyc = 0;
  bit          armed = 0;

  always @(negedge clk) begin
    logic        exp_ov;
    logic [27:0] e;
    exp_ov = pending && (cyc >= acc_cyc + NW + 1);
    if (armed) begin
      chk("in_ready", in_ready, !pending);
      chk("in_ready8", in_ready8, !pending);
      chk("out_valid", out_valid, exp_ov);
      chk("out_valid8", out_valid8, exp_ov);
      if (exp_ov && exp_q.size() > 0) begin
        e = exp_q[0];
        chk("out_temp", out_temp, e[15:0]);
        chk("out_sat", out_sat, e[16]);
        chk("out_temp8", out_temp8, e[24:17]);
        chk("out_sat8", out_sat8, e[25]);
        chk("out_ch", out_ch, e[27:26]);
        chk("out_ch8", out_ch8, e[27:26]);
      end
    end
    if (reset) begin
      exp_q.delete();
      pending = 0;
      armed = 1;
    end else if (armed) begin
      if (exp_ov && out_ready) begin
        void'(exp_q.pop_front());
        pending = 0;
      end else if (!pending && in_valid) begin
        exp_q.push_back(model(in_temp, in_mode, in_ch));
        pending = 1;
        acc_cyc = cyc + 1;
      end
    end
  end

  // Drivers are called just after a rising edge and return just after one.
  task automatic send(input int t, input logic m, input logic [1:0] ch);
    bit done;
    done = 0;
    in_temp = t[7:0];
    in_mode = m;
    in_ch = ch;
    in_valid = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1;
        present_cyc = cyc;
      end
    end
    if (!done) begin
      n_chk++;
      n_err++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        valid_cyc = cyc;
      end
    end
    if (!ok) begin
      n_chk++;
      n_err++;
      $display("FAIL valid_timeout: got out_valid=0 expected 1 within 100 cycles");
    end
  endtask

  task automatic directed(input int t, input logic m, input logic [1:0] ch, input int e16,
                          input int e8, input logic es8, input bit chk_lat);
    bit ok;
    send(t, m, ch);
    wait_valid(ok);
    if (ok) begin
      chk("dir_temp", out_temp, e16[15:0]);
      chk("dir_ch", out_ch, ch);
      chk("dir_sat", out_sat, 1'b0);
      chk("dir_temp8", out_temp8, e8[7:0]);
      chk("dir_sat8", out_sat8, es8);
      if (chk_lat) chk("latency", valid_cyc - present_cyc, 14);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         ok;
    int         t, gap;
    logic       m;
    logic [1:0] c;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_temp", out_temp, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_sat", out_sat, 1'b0);
    chk("rst_out_temp8", out_temp8, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;

    directed(25, 0, 1, 77, 77, 0, 1);
    directed(37, 0, 0, 99, 99, 0, 0);
    directed(-1, 0, 2, 30, 30, 0, 0);
    directed(-40, 0, 0, -40, -40, 0, 0);
    directed(100, 1, 0, 38, 38, 0, 0);
    directed(-40, 1, 1, -40, -40, 0, 0);
    directed(32, 1, 3, 0, 0, 0, 0);
    directed(127, 0, 0, 261, 127, 1, 0);
    directed(-128, 0, 2, -198, -128, 1, 0);

    // Backpressure: result held while out_ready is low; a sample offered meanwhile is refused.
    out_ready = 1'b0;
    send(25, 0, 1);
    wait_valid(ok);
    @(posedge clk);
    #1;
    in_temp = 8'd50;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_temp", out_temp, 77);
      chk("bp_ch", out_ch, 1);
      chk("bp_sat", out_sat, 1'b0);
      chk("bp_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1'b1);
    chk("bp_release_out_valid", out_valid, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Reset during the fifth divide cycle aborts the sample.
    send(25, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    directed(25, 0, 1, 77, 77, 0, 1);

    for (int i = 0; i < 60; i++) begin
      t = int'($urandom_range(0, 255)) - 128;
      m = 1'($urandom_range(0, 1));
      c = 2'($urandom_range(0, 3));
      gap = int'($urandom_range(0, 2));
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      send(t, m, c);
      out_ready = 1'($urandom_range(0, 1));
      wait_valid(ok);
      @(posedge clk);
      #1;
      gap = int'($urandom_range(0, 3));
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      out_ready = 1'b1;
    end

    repeat (20) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
